// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard controls, branch redirect, instruction memory and IF/ID outputs.
// master = fetch stage side, slave = surrounding pipeline / memory side.
interface fetch_stage_if;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    modport master (
        input  pc_write, ifid_write, ifid_flush, branch_taken, branch_target, imem_rdata,
        output imem_addr, ifid_pc, ifid_instr, ifid_valid, stall_cycles, flush_count
    );

    modport slave (
        output pc_write, ifid_write, ifid_flush, branch_taken, branch_target, imem_rdata,
        input  imem_addr, ifid_pc, ifid_instr, ifid_valid, stall_cycles, flush_count
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, queued branch redirect across PC stalls, IF/ID register; optional FETCH_PERF_EN counters.
// Latency: one cycle from imem_addr to IF/ID; redirect visible on imem_addr one cycle after it is applied.
// Backpressure: pc_write=0 holds the PC (a taken branch is queued), ifid_write=0 holds IF/ID.
module fetch_stage #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);
    typedef enum logic {IDLE, PENDING} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pend_target;
    logic [31:0] branch_aligned;
    logic [31:0] ifid_pc_q;
    logic [31:0] ifid_instr_q;
    logic        ifid_valid_q;

    assign branch_aligned = {bus.branch_target[31:2], 2'b00};

    // A redirect arriving while the PC is stalled is parked in pend_target;
    // a fresh redirect in the release cycle supersedes the parked one.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= PC_RESET;
            state       <= IDLE;
            pend_target <= '0;
        end else if (bus.pc_write) begin
            if (bus.branch_taken)
                pc <= branch_aligned;
            else if (state == PENDING)
                pc <= pend_target;
            else
                pc <= pc + 32'd4;
            state <= IDLE;
        end else if (bus.branch_taken) begin
            state       <= PENDING;
            pend_target <= branch_aligned;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.ifid_flush) begin
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end else if (bus.ifid_write) begin
            ifid_pc_q    <= pc;
            ifid_instr_q <= bus.imem_rdata;
            ifid_valid_q <= 1'b1;
        end
    end

    assign bus.imem_addr  = pc;
    assign bus.ifid_pc    = ifid_pc_q;
    assign bus.ifid_instr = ifid_instr_q;
    assign bus.ifid_valid = ifid_valid_q;

`ifdef FETCH_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!bus.ifid_write && !bus.ifid_flush && stall_q != 32'hFFFF_FFFF)
                stall_q <= stall_q + 32'd1;
            if (bus.ifid_flush && flush_q != 32'hFFFF_FFFF)
                flush_q <= flush_q + 32'd1;
        end
    end

    assign bus.stall_cycles = stall_q;
    assign bus.flush_count  = flush_q;
`else
    assign bus.stall_cycles = '0;
    assign bus.flush_count  = '0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, free-run, stalls, flush, direct/pended redirect, PC wrap, reset in PENDING.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Combinational instruction memory: word = address ^ A5A5_0000.
    assign bus.imem_rdata = bus.imem_addr ^ 32'hA5A5_0000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_perf(input string tag, input logic [31:0] exp_stall, input logic [31:0] exp_flush);
`ifdef FETCH_PERF_EN
        check({tag, "_stall"}, bus.stall_cycles, exp_stall);
        check({tag, "_flush"}, bus.flush_count, exp_flush);
`else
        check({tag, "_stall"}, bus.stall_cycles, 32'd0);
        check({tag, "_flush"}, bus.flush_count, 32'd0);
        if (exp_stall == 32'hFFFF_FFFF || exp_flush == 32'hFFFF_FFFF) $display("unexpected count");
`endif
    endtask

    initial begin
        rst               = 1'b1;
        bus.pc_write      = 1'b1;
        bus.ifid_write    = 1'b1;
        bus.ifid_flush    = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0;
        tick();
        tick();

        check("rst_addr", bus.imem_addr, 32'h0);
        check("rst_ifid_pc", bus.ifid_pc, 32'h0);
        check("rst_instr", bus.ifid_instr, 32'h0000_0013);
        check("rst_valid", {31'd0, bus.ifid_valid}, 32'd0);
        check_perf("rst", 32'd0, 32'd0);

        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("run_pc", bus.ifid_pc, 32'(4 * i));
            check("run_instr", bus.ifid_instr, 32'(4 * i) ^ 32'hA5A5_0000);
            check("run_valid", {31'd0, bus.ifid_valid}, 32'd1);
        end
        check("run_addr", bus.imem_addr, 32'h10);

        // Two-cycle stall at PC 0x10.
        bus.pc_write   = 1'b0;
        bus.ifid_write = 1'b0;
        tick();
        tick();
        check("stall_addr", bus.imem_addr, 32'h10);
        check("stall_ifid_pc", bus.ifid_pc, 32'hC);
        check("stall_instr", bus.ifid_instr, 32'hA5A5_000C);
        check_perf("stall", 32'd2, 32'd0);

        // Direct redirect with flush; low target bits dropped.
        bus.pc_write      = 1'b1;
        bus.ifid_write    = 1'b1;
        bus.ifid_flush    = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h0000_0103;
        tick();
        check("br_addr", bus.imem_addr, 32'h100);
        check("br_instr", bus.ifid_instr, 32'h0000_0013);
        check("br_valid", {31'd0, bus.ifid_valid}, 32'd0);
        check("br_ifid_pc", bus.ifid_pc, 32'h0);
        check_perf("br", 32'd2, 32'd1);
        bus.ifid_flush   = 1'b0;

        // Redirect during PC stall, one more stall cycle, then release.
        bus.pc_write      = 1'b0;
        bus.branch_target = 32'h200;
        tick();
        check("pend_hold", bus.imem_addr, 32'h100);
        check("pend_refetch", bus.ifid_pc, 32'h100);
        bus.branch_taken = 1'b0;
        tick();
        check("pend_hold2", bus.imem_addr, 32'h100);
        check("pend_refetch2", bus.ifid_pc, 32'h100);
        bus.pc_write = 1'b1;
        tick();
        check("pend_apply", bus.imem_addr, 32'h200);
        tick();
        check("pend_idle", bus.imem_addr, 32'h204);

        // Newer redirect in the release cycle beats the parked one.
        bus.pc_write      = 1'b0;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h200;
        tick();
        check("over_hold", bus.imem_addr, 32'h204);
        bus.pc_write      = 1'b1;
        bus.branch_target = 32'h300;
        tick();
        check("over_apply", bus.imem_addr, 32'h300);
        bus.branch_taken = 1'b0;
        tick();
        check("over_idle", bus.imem_addr, 32'h304);

        // PC wrap.
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'hFFFF_FFFF;
        tick();
        check("wrap_top", bus.imem_addr, 32'hFFFF_FFFC);
        bus.branch_taken = 1'b0;
        tick();
        check("wrap_zero", bus.imem_addr, 32'h0);

        // Reset while PENDING discards the queued target.
        bus.pc_write      = 1'b0;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h400;
        tick();
        check("rpend_hold", bus.imem_addr, 32'h0);
        bus.branch_taken = 1'b0;
        rst = 1'b1;
        tick();
        check("rpend_addr", bus.imem_addr, 32'h0);
        check("rpend_valid", {31'd0, bus.ifid_valid}, 32'd0);
        check_perf("rpend", 32'd0, 32'd0);
        rst          = 1'b0;
        bus.pc_write = 1'b1;
        tick();
        check("rpend_noredir", bus.imem_addr, 32'h4);
        check("rpend_first", bus.ifid_pc, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage pipeline. It holds the program counter, drives the instruction-memory address, and loads the IF/ID pipeline register. It obeys the `pc_write`, `ifid_write` and `ifid_flush` controls from the hazard unit. It also queues a taken-branch redirect that arrives during a PC stall, so the redirect is applied once the stall releases.

## Interface
Parameters:
- `PC_RESET`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, default 32'h0000_0013: bubble instruction (`addi x0,x0,0`) inserted on flush and reset.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous active-high reset.
- `pc_write`  in  1  1 = PC may advance or redirect; 0 = PC holds.
- `ifid_write`  in  1  1 = IF/ID loads new fetch; 0 = IF/ID holds.
- `ifid_flush`  in  1  1 = IF/ID loads a bubble.
- `branch_taken`  in  1  taken branch resolved this cycle (`branch & zero` from EX).
- `branch_target`  in  32  redirect address; bits [1:0] are ignored and forced to 0.
- `imem_addr`  out  32  instruction-memory address; equals the PC register.
- `imem_rdata`  in  32  instruction at `imem_addr`, valid in the same cycle (combinational memory).
- `ifid_pc`  out  32  PC of the instruction held in IF/ID.
- `ifid_instr`  out  32  instruction held in IF/ID.
- `ifid_valid`  out  1  1 = IF/ID holds a real instruction, not a bubble.
- `stall_cycles`  out  32  performance counter (see Configuration).
- `flush_count`  out  32  performance counter (see Configuration).

## Operation
- PC register update, highest priority first:
  1. `rst`: PC <= `PC_RESET`.
  2. `pc_write` = 1 and `branch_taken` = 1: PC <= {`branch_target`[31:2], 2'b00}.
  3. `pc_write` = 1 and state PENDING: PC <= `pend_target`.
  4. `pc_write` = 1 otherwise: PC <= PC + 4. The add is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  5. `pc_write` = 0: PC holds.
- Redirect FSM, two states, reset state IDLE:
  - IDLE -> PENDING when `branch_taken` = 1 and `pc_write` = 0. The target is captured in `pend_target`.
  - PENDING -> PENDING on a further `branch_taken` with `pc_write` = 0. The newer target overwrites `pend_target`.
  - PENDING -> IDLE on any cycle with `pc_write` = 1. A simultaneous `branch_taken` wins over the stored target.
  - IDLE -> IDLE on `branch_taken` with `pc_write` = 1; the redirect is applied directly.
  - `rst` forces IDLE and clears `pend_target` to 0.
- IF/ID register update, highest priority first:
  1. `rst`: `ifid_pc` = 0, `ifid_instr` = `NOP_INSTR`, `ifid_valid` = 0.
  2. `ifid_flush`: same values as reset. Flush wins over `ifid_write`.
  3. `ifid_write`: `ifid_pc` <= PC, `ifid_instr` <= `imem_rdata`, `ifid_valid` <= 1.
  4. Otherwise all three fields hold.
- `ifid_write` = 1 with `pc_write` = 0 is legal: the same PC is fetched again into IF/ID.

## Timing
- Reset values:
  - `imem_addr` = `PC_RESET`.
  - `ifid_pc` = 0, `ifid_instr` = `NOP_INSTR`, `ifid_valid` = 0.
  - `stall_cycles` = 0, `flush_count` = 0.
  - FSM in IDLE.
- The first fetch address appears in the cycle after `rst` deasserts. The first valid IF/ID word appears one edge later.
- Fetch latency is one cycle: the address presented in cycle N appears in IF/ID after edge N.
- Redirect latency:
  - Direct redirect: `imem_addr` = target one cycle after `branch_taken` with `pc_write` = 1.
  - Pended redirect: `imem_addr` = target one cycle after the first cycle in which `pc_write` = 1.
- All outputs are registered except `imem_addr`, which is a direct copy of the PC register.
- `rst` asserted during PENDING discards the queued target.

## Configuration
- Macro `FETCH_PERF_EN`.
- When defined:
  - `stall_cycles` increments on each cycle with `ifid_write` = 0, `ifid_flush` = 0 and `rst` = 0.
  - `flush_count` increments on each cycle with `ifid_flush` = 1 and `rst` = 0.
  - Both counters are 32-bit, saturate at 32'hFFFF_FFFF, and clear on `rst`.
- When undefined: both ports are tied to constant 0 and no counter flops are built.

## Test plan
- Reset, then free-run with `pc_write` = `ifid_write` = 1 and `imem_rdata` = PC ^ 32'hA5A5_0000 -> `ifid_pc` steps 0, 4, 8, 12, with matching `ifid_instr` and `ifid_valid` = 1.
- Hold `pc_write` = `ifid_write` = 0 for 2 cycles at PC = 0x10 -> `imem_addr` stays 0x10 and IF/ID stays frozen. With `FETCH_PERF_EN`, `stall_cycles` = 2.
- `branch_taken` = 1, target 0x0000_0103, `pc_write` = 1, `ifid_flush` = 1 -> next `imem_addr` = 0x100, `ifid_instr` = 0x0000_0013, `ifid_valid` = 0, `flush_count` increments by 1.
- `branch_taken` with target 0x200 while `pc_write` = 0, then 1 stall cycle, then `pc_write` = 1 -> `imem_addr` = 0x200 on the cycle after release, and the FSM returns to IDLE.
- While PENDING with target 0x200, a new `branch_taken` with target 0x300 arrives together with `pc_write` = 1 -> `imem_addr` = 0x300.
- PC = 0xFFFF_FFFC with `pc_write` = 1 -> `imem_addr` = 0. Separately, `rst` asserted during PENDING -> after release `imem_addr` = `PC_RESET`, with no redirect.
